// File: rtl/cpu_pipe_pkg.sv
// Shared types and helpers for the CPU pipeline-stage registers.
// Occupancy encoding and its decode live here so every stage counts alike.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  localparam int PIPE_MAX_OCC = 2;

  // Occupancy decode; the unused 2'b11 encoding reads as empty.
  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      PS_ONE:  return 2'd1;
      PS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Handshake controller for pipe_stage_reg: occupancy FSM, ready/valid decode
// and the load enables that steer the data registers in the parent.
module pipe_stage_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned SKID = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       out_ready,
  input  logic       flush,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] count,
  output logic       load_main_from_in,
  output logic       load_main_from_skid,
  output logic       load_skid
);

  localparam bit HAS_SKID = (SKID != 0);

  pipe_state_t state;
  pipe_state_t state_nxt;
  logic        in_fire;
  logic        out_fire;

  assign out_valid = (state != PS_EMPTY);
  assign count     = occ_of(state);

  generate
    if (HAS_SKID) begin : g_ready_skid
      // Pure decode of the state flop: no path from out_ready to in_ready.
      assign in_ready = (state != PS_FULL);
    end else begin : g_ready_pass
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned; that is what keeps latches from being inferred.
    state_nxt           = state;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;

    case (state)
      PS_EMPTY: begin
        if (in_fire) begin
          state_nxt         = PS_ONE;
          load_main_from_in = 1'b1;
        end
      end
      PS_ONE: begin
        if (in_fire && (out_fire || !HAS_SKID)) begin
          load_main_from_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = PS_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (!HAS_SKID) begin
          state_nxt = PS_EMPTY;
        end else if (out_fire) begin
          state_nxt           = PS_ONE;
          load_main_from_skid = 1'b1;
        end
      end
      default: state_nxt = PS_EMPTY;
    endcase

    // Flush discards everything held plus any same-edge input; the data
    // registers keep their contents since they are don't-care while empty.
    if (flush) begin
      state_nxt           = PS_EMPTY;
      load_main_from_in   = 1'b0;
      load_main_from_skid = 1'b0;
      load_skid           = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from before the edge, independent of order.
    if (!rst) state <= PS_EMPTY;
    else      state <= state_nxt;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer (SKID=1) for registered in_ready.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      SKID    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  logic             load_main_from_in;
  logic             load_main_from_skid;
  logic             load_skid;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  pipe_stage_ctrl #(
    .SKID(SKID)
  ) u_ctrl (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .out_ready          (out_ready),
    .flush              (flush),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .count              (count),
    .load_main_from_in  (load_main_from_in),
    .load_main_from_skid(load_main_from_skid),
    .load_skid          (load_skid)
  );

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data registers are reset as well, so out_data shows RST_VAL
    // rather than X out of reset; plain pipeline data could skip this.
    if (!rst) begin
      main_q <= RST_VAL;
    end else if (load_main_from_skid) begin
      main_q <= skid_q;
    end else if (load_main_from_in) begin
      main_q <= in_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)           skid_q <= RST_VAL;
        else if (load_skid) skid_q <= in_data;
      end
    end else begin : g_no_skid
      // Single-entry build: load_skid and load_main_from_skid never assert.
      logic skid_unused;
      assign skid_unused = load_skid;
      assign skid_q      = RST_VAL;
    end
  endgenerate

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance
// share stimulus; a queue of accepted items predicts occupancy and output.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_data1, out_data0;
  logic [1:0]  count1, count0;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_popped = 0;
  bit          mode_skid;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .RST_VAL(RV), .SKID(1)) u_dut_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .flush(flush), .count(count1)
  );

  pipe_stage_reg #(.WIDTH(32), .RST_VAL(RV), .SKID(0)) u_dut_pass (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .flush(flush), .count(count0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at posedge+2: drive, check at posedge+3, update model, advance.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic        irdy, ovld, exp_ir, fi, fo;
    logic [31:0] odat;
    logic [1:0]  cnt;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
    irdy = mode_skid ? in_ready1  : in_ready0;
    ovld = mode_skid ? out_valid1 : out_valid0;
    odat = mode_skid ? out_data1  : out_data0;
    cnt  = mode_skid ? count1     : count0;
    exp_ir = mode_skid ? (sb.size() < 2) : (sb.size() == 0 || r);
    check("in_ready",  32'(irdy), 32'(exp_ir));
    check("out_valid", 32'(ovld), 32'(sb.size() != 0));
    check("count",     32'(cnt),  32'(sb.size()));
    if (sb.size() != 0) check("out_data", odat, sb[0]);
    fo = (sb.size() != 0) && r;
    fi = v && exp_ir;
    if (fo) begin
      void'(sb.pop_front());
      n_popped++;
    end
    if (f) sb.delete();
    else if (fi) sb.push_back(d);
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset: outputs must change before any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid1), 32'd0);
    check("rst_out_data",  out_data1, RV);
    check("rst_count",     32'(count1), 32'd0);
    check("rst_in_ready",  32'(in_ready1), 32'd1);
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_out_data0", out_data0, RV);
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] pat;
    int idx, cyc;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    mode_skid = 1'b1;
    #3;
    do_reset();

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill both entries under back-pressure, hold, then drain
    step(1'b1, 32'hA5, 1'b0, 1'b0);
    step(1'b1, 32'h5A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Input offered while full must wait, not overwrite
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b1, 32'h77, 1'b1, 1'b0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a concurrent input
    step(1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of a transfer, input still offered
    step(1'b1, 32'h66, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h67;
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);

    // Single-entry variant: out_ready cycles 1,0,1 with continuous input
    mode_skid = 1'b0;
    do_reset();
    n_popped = 0;
    pat = 3'b101;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      acc = (sb.size() == 0) || pat[cyc % 3];
      step(1'b1, 32'h100 + 32'(idx), pat[cyc % 3], 1'b0);
      if (acc) idx++;
      cyc++;
    end
    check("pass_accepted", 32'(idx), 32'd16);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pass_delivered", 32'(n_popped), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
